// File: rtl/secret_cyc_bank_if.sv
// Control and observation bundle for secret_cyc_bank.
// The master drives start/ch_en/step_i; the slave (the bank) returns all counters and status.
interface secret_cyc_bank_if #(
  parameter int NUM_CH = 2,
  parameter int CW     = 32,
  parameter int STEP_W = 4
);
  logic                     start;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*STEP_W-1:0] step_i;
  logic [CW-1:0]            gcyc_o;
  logic [NUM_CH*CW-1:0]     cyc_o;
  logic [NUM_CH*CW-1:0]     field_o;
  logic [NUM_CH*CW-1:0]     field_r_o;
  logic [1:0]               state_o;
  logic                     finished_o;
  logic                     done_o;
  logic [NUM_CH-1:0]        ovf_o;

  modport master (
    output start, ch_en, step_i,
    input  gcyc_o, cyc_o, field_o, field_r_o, state_o, finished_o, done_o, ovf_o
  );

  modport slave (
    input  start, ch_en, step_i,
    output gcyc_o, cyc_o, field_o, field_r_o, state_o, finished_o, done_o, ovf_o
  );
endinterface

// File: rtl/secret_cyc_bank.sv
// Multi-channel cycle/accumulator bank with an IDLE/RUN/DONE run sequencer.
// Optional sticky wrap flags are built only when SECRET_CYC_BANK_OVF_EN is defined.
module secret_cyc_bank #(
  parameter int NUM_CH  = 2,
  parameter int CW      = 32,
  parameter int STEP_W  = 4,
  parameter int FIN_CYC = 90,
  parameter int END_CYC = 99
) (
  input  logic            clk,
  input  logic            rst_n,
  secret_cyc_bank_if.slave bus
);

  // start is a level request with no ready: it is honoured on any edge seen in
  // IDLE or DONE and ignored in RUN; ch_en/step_i only matter on RUN edges.

`ifdef SECRET_CYC_BANK_OVF_EN
  localparam int SUM_W = CW + 1;
`else
  localparam int SUM_W = CW;
`endif

  localparam logic [CW-1:0] FIN_V = CW'(FIN_CYC);
  localparam logic [CW-1:0] END_V = CW'(END_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic          clear_all;
  logic          advance;
  logic [CW-1:0] gcyc_q;
  logic [CW-1:0] gcyc_inc;
  logic          finished_q;
  logic          done_q;

  assign gcyc_inc = gcyc_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    clear_all = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_RUN;
          clear_all = 1'b1;
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (gcyc_inc == END_V) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Restart rather than resume: every counter starts again from zero.
        if (bus.start) begin
          state_nxt = ST_RUN;
          clear_all = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcyc_q     <= '0;
      finished_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      finished_q <= advance && (gcyc_inc == FIN_V);
      done_q     <= (state_nxt == ST_DONE);
      if (clear_all) begin
        gcyc_q <= '0;
      end else if (advance) begin
        gcyc_q <= gcyc_inc;
      end
    end
  end

  assign bus.gcyc_o     = gcyc_q;
  assign bus.state_o    = state_q;
  assign bus.finished_o = finished_q;
  assign bus.done_o     = done_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [STEP_W-1:0] step_k;
    logic              adv_k;
    logic [CW-1:0]     cyc_q;
    logic [CW-1:0]     fld_q;
    logic [CW-1:0]     fldr_q;
    logic [SUM_W-1:0]  cyc_sum;
    logic [SUM_W-1:0]  fld_sum;
    logic [SUM_W-1:0]  fldr_sum;

    assign step_k   = bus.step_i[k*STEP_W +: STEP_W];
    assign adv_k    = advance & bus.ch_en[k];
    assign cyc_sum  = SUM_W'(cyc_q) + SUM_W'(step_k);
    assign fld_sum  = SUM_W'(fld_q) + SUM_W'(1'b1);
    assign fldr_sum = SUM_W'(fldr_q) + SUM_W'(2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cyc_q  <= '0;
        fld_q  <= '0;
        fldr_q <= '0;
      end else if (clear_all) begin
        cyc_q  <= '0;
        fld_q  <= '0;
        fldr_q <= '0;
      end else if (adv_k) begin
        cyc_q  <= cyc_sum[CW-1:0];
        fld_q  <= fld_sum[CW-1:0];
        fldr_q <= fldr_sum[CW-1:0];
      end
    end

    assign bus.cyc_o[k*CW +: CW]     = cyc_q;
    assign bus.field_o[k*CW +: CW]   = fld_q;
    assign bus.field_r_o[k*CW +: CW] = fldr_q;

`ifdef SECRET_CYC_BANK_OVF_EN
    logic ovf_q;
    logic wrap_k;

    // Carry-out of any of the three adders marks the channel as having wrapped.
    assign wrap_k = cyc_sum[CW] | fld_sum[CW] | fldr_sum[CW];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_q <= 1'b0;
      end else if (clear_all) begin
        ovf_q <= 1'b0;
      end else if (adv_k && wrap_k) begin
        ovf_q <= 1'b1;
      end
    end

    assign bus.ovf_o[k] = ovf_q;
`endif
  end

`ifndef SECRET_CYC_BANK_OVF_EN
  assign bus.ovf_o = '0;
`endif

endmodule
